// File: rtl/bf_pkg.sv
// Opcode encodings, sequencer states and pointer defaults shared by bf_core.
package bf_pkg;

   localparam logic [7:0] PcStartDefault  = 8'h00;
   localparam logic [7:0] DataBaseDefault = 8'h80;

   localparam logic [7:0] OpInc   = 8'h2B;
   localparam logic [7:0] OpDec   = 8'h2D;
   localparam logic [7:0] OpRight = 8'h3E;
   localparam logic [7:0] OpLeft  = 8'h3C;
   localparam logic [7:0] OpOut   = 8'h2E;
   localparam logic [7:0] OpIn    = 8'h2C;
   localparam logic [7:0] OpLoopL = 8'h5B;
   localparam logic [7:0] OpLoopR = 8'h5D;
   localparam logic [7:0] OpHalt  = 8'h00;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StExec,
      StWrite,
      StOut,
      StIn,
      StScanfA,
      StScanfC,
      StScanbA,
      StScanbC,
      StHalt
   } bf_state_e;

endpackage

// File: rtl/bf_core.sv
// Brainfuck execution sequencer: fetches from a shared registered-output SRAM, executes,
// writes back through its single write port, with ready/valid byte I/O.
module bf_core
   import bf_pkg::*;
#(
   parameter logic [7:0] PC_START  = PcStartDefault,
   parameter logic [7:0] DATA_BASE = DataBaseDefault
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   output logic [7:0] o_instptr,
   output logic [7:0] o_dataptr,
   output logic       o_memwrite,
   output logic [7:0] o_datain,
   input  logic [7:0] i_instr,
   input  logic [7:0] i_data,
   output logic [7:0] o_out_data,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   input  logic [7:0] i_in_data,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   output logic       o_busy,
   output logic       o_halted,
   output logic       o_error
);

   bf_state_e  r_state, w_state_nxt;
   logic [7:0] r_pc, w_pc_nxt;
   logic [7:0] r_dp, w_dp_nxt;
   logic [7:0] r_depth, w_depth_nxt;
   logic [7:0] r_datain, w_datain_nxt;
   logic [7:0] r_out_data, w_out_data_nxt;
   logic       r_memwrite, w_memwrite_nxt;
   logic       r_out_valid, w_out_valid_nxt;
   logic       r_in_ready, w_in_ready_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_halted, w_halted_nxt;
   logic       r_error, w_error_nxt;
   logic       w_stop, w_fault;
   logic [7:0] w_pc_inc, w_pc_dec;

   assign w_pc_inc = r_pc + 8'd1;
   assign w_pc_dec = r_pc - 8'd1;

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_dp_nxt        = r_dp;
      w_depth_nxt     = r_depth;
      w_datain_nxt    = r_datain;
      w_out_data_nxt  = r_out_data;
      w_memwrite_nxt  = 1'b0;
      w_out_valid_nxt = r_out_valid;
      w_in_ready_nxt  = r_in_ready;
      w_busy_nxt      = r_busy;
      w_halted_nxt    = r_halted;
      w_error_nxt     = r_error;
      w_stop          = 1'b0;
      w_fault         = 1'b0;
      case (r_state)
         StIdle, StHalt: begin
            if (i_start) begin
               w_state_nxt  = StFetch;
               w_pc_nxt     = PC_START;
               w_dp_nxt     = DATA_BASE;
               w_busy_nxt   = 1'b1;
               w_halted_nxt = 1'b0;
               w_error_nxt  = 1'b0;
            end
         end
         StFetch:  w_state_nxt = StExec;
         StExec: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = StFetch;
            case (i_instr)
               OpInc, OpDec: begin
                  w_datain_nxt   = (i_instr == OpInc) ? i_data + 8'd1 : i_data - 8'd1;
                  w_memwrite_nxt = 1'b1;
                  w_state_nxt    = StWrite;
               end
               OpRight: w_dp_nxt = r_dp + 8'd1;
               OpLeft:  w_dp_nxt = r_dp - 8'd1;
               OpOut: begin
                  w_pc_nxt        = r_pc;
                  w_out_data_nxt  = i_data;
                  w_out_valid_nxt = 1'b1;
                  w_state_nxt     = StOut;
               end
               OpIn: begin
                  w_pc_nxt       = r_pc;
                  w_in_ready_nxt = 1'b1;
                  w_state_nxt    = StIn;
               end
               OpLoopL: begin
                  if (i_data == 8'd0) begin
                     // Starting a forward scan from 0xFF would already wrap.
                     w_stop      = (r_pc == 8'hFF);
                     w_fault     = (r_pc == 8'hFF);
                     w_depth_nxt = 8'd1;
                     w_state_nxt = StScanfA;
                  end
               end
               OpLoopR: begin
                  if (i_data != 8'd0) begin
                     w_stop      = (r_pc == 8'h00);
                     w_fault     = (r_pc == 8'h00);
                     w_depth_nxt = 8'd1;
                     w_pc_nxt    = w_pc_dec;
                     w_state_nxt = StScanbA;
                  end
               end
               OpHalt:  w_stop = 1'b1;
               default: ;
            endcase
         end
         StWrite:  w_state_nxt = StFetch;
         StOut: begin
            if (i_out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_pc_nxt        = w_pc_inc;
               w_state_nxt     = StFetch;
            end
         end
         StIn: begin
            if (i_in_valid) begin
               w_in_ready_nxt = 1'b0;
               w_datain_nxt   = i_in_data;
               w_memwrite_nxt = 1'b1;
               w_pc_nxt       = w_pc_inc;
               w_state_nxt    = StWrite;
            end
         end
         StScanfA: w_state_nxt = StScanfC;
         StScanfC: begin
            if (i_instr == OpLoopR && r_depth == 8'd1) begin
               w_depth_nxt = 8'd0;
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = StFetch;
            end else if (r_pc == 8'hFF || (i_instr == OpLoopL && r_depth == 8'hFF)) begin
               w_stop  = 1'b1;
               w_fault = 1'b1;
            end else begin
               if (i_instr == OpLoopL) w_depth_nxt = r_depth + 8'd1;
               if (i_instr == OpLoopR) w_depth_nxt = r_depth - 8'd1;
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = StScanfA;
            end
         end
         StScanbA: w_state_nxt = StScanbC;
         StScanbC: begin
            if (i_instr == OpLoopL && r_depth == 8'd1) begin
               w_depth_nxt = 8'd0;
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = StFetch;
            end else if (r_pc == 8'h00 || (i_instr == OpLoopR && r_depth == 8'hFF)) begin
               w_stop  = 1'b1;
               w_fault = 1'b1;
            end else begin
               if (i_instr == OpLoopR) w_depth_nxt = r_depth + 8'd1;
               if (i_instr == OpLoopL) w_depth_nxt = r_depth - 8'd1;
               w_pc_nxt    = w_pc_dec;
               w_state_nxt = StScanbA;
            end
         end
         default:  w_state_nxt = StIdle;
      endcase
      // Halting freezes the PC where execution or the failed scan stopped.
      if (w_stop) begin
         w_pc_nxt     = r_pc;
         w_state_nxt  = StHalt;
         w_busy_nxt   = 1'b0;
         w_halted_nxt = 1'b1;
         if (w_fault) w_error_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_pc        <= PC_START;
         r_dp        <= DATA_BASE;
         r_depth     <= 8'd0;
         r_datain    <= 8'd0;
         r_out_data  <= 8'd0;
         r_memwrite  <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_dp        <= w_dp_nxt;
         r_depth     <= w_depth_nxt;
         r_datain    <= w_datain_nxt;
         r_out_data  <= w_out_data_nxt;
         r_memwrite  <= w_memwrite_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_busy      <= w_busy_nxt;
         r_halted    <= w_halted_nxt;
         r_error     <= w_error_nxt;
      end
   end

   assign o_instptr   = r_pc;
   assign o_dataptr   = r_dp;
   assign o_memwrite  = r_memwrite;
   assign o_datain    = r_datain;
   assign o_out_data  = r_out_data;
   assign o_out_valid = r_out_valid;
   assign o_in_ready  = r_in_ready;
   assign o_busy      = r_busy;
   assign o_halted    = r_halted;
   assign o_error     = r_error;

endmodule

// File: tb/tb_bf_core.sv
// Bench for bf_core: behavioural 256-byte SRAM, directed programs, output scoreboard.
module tb_bf_core;

   logic       clk = 1'b0;
   logic       rst_n, start, start0, load;
   logic       out_ready, in_valid;
   logic [7:0] in_data;
   logic [7:0] instr, data, instptr, dataptr, datain, out_data;
   logic       memwrite, out_valid, in_ready, busy, halted, error;
   logic [7:0] mem  [256];
   logic [7:0] prog [256];
   logic [7:0] exp_q [$];
   int         n_checks = 0;
   int         n_errors = 0;

   // Second instance with DATA_BASE=0 and a fixed "<" program ROM.
   logic [7:0] instr0, data0, instptr0, dataptr0, datain0, out_data0;
   logic       memwrite0, out_valid0, in_ready0, busy0, halted0, error0;

   always #5 clk = ~clk;

   bf_core u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(start),
      .o_instptr(instptr), .o_dataptr(dataptr), .o_memwrite(memwrite), .o_datain(datain),
      .i_instr(instr), .i_data(data),
      .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
      .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .o_busy(busy), .o_halted(halted), .o_error(error)
   );

   bf_core #(.PC_START(8'h00), .DATA_BASE(8'h00)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_start(start0),
      .o_instptr(instptr0), .o_dataptr(dataptr0), .o_memwrite(memwrite0), .o_datain(datain0),
      .i_instr(instr0), .i_data(data0),
      .o_out_data(out_data0), .o_out_valid(out_valid0), .i_out_ready(1'b1),
      .i_in_data(8'h00), .i_in_valid(1'b0), .o_in_ready(in_ready0),
      .o_busy(busy0), .o_halted(halted0), .o_error(error0)
   );

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      end else if (memwrite) begin
         mem[dataptr] <= datain;
      end
      instr  <= mem[instptr];
      data   <= mem[dataptr];
      instr0 <= (instptr0 == 8'h00) ? 8'h3C : 8'h00;
      data0  <= 8'h00;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b, required %0b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every cycle out_valid is up, out_data must equal the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_unexpected: got 0x%02h, required no output", out_data);
         end else begin
            chk8("out_data", out_data, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic begin_test(input string p);
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) prog[i] = 8'h00;
      for (int i = 0; i < p.len(); i++) prog[i] = p[i];
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start = 1'b1;
   endtask

   task automatic wait_halt(input string name, input int budget, output int cyc);
      int n;
      n = 0;
      while (n < budget && !halted) begin
         step();
         n++;
      end
      cyc = n;
      if (!halted) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: halted=0 after %0d cycles, required 1", name, budget);
      end
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      while (n < 30 && !out_valid) begin
         step();
         n++;
      end
      chk1(name, out_valid, 1'b1);
   endtask

   initial begin
      int cyc;
      int n;
      rst_n = 1'b0; start = 1'b0; start0 = 1'b0; load = 1'b0;
      out_ready = 1'b1; in_valid = 1'b0; in_data = 8'h00;

      // Reset values, then idle without start.
      @(posedge clk);
      #1;
      chk8("rst_instptr", instptr, 8'h00);
      chk8("rst_dataptr", dataptr, 8'h80);
      chk1("rst_memwrite", memwrite, 1'b0);
      chk8("rst_datain", datain, 8'h00);
      chk8("rst_out_data", out_data, 8'h00);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk1("rst_error", error, 1'b0);
      rst_n = 1'b1;
      repeat (4) step();
      chk1("idle_busy", busy, 1'b0);

      // "+++." : one output 0x03, halts at 0x04.
      exp_q.push_back(8'h03);
      begin_test("+++.");
      wait_halt("inc", 100, cyc);
      chk32("inc_cycles", cyc, 15);
      chk8("inc_instptr", instptr, 8'h04);
      chk8("inc_mem80", mem[8'h80], 8'h03);
      chk1("inc_busy", busy, 1'b0);
      chk1("inc_error", error, 1'b0);
      chk32("inc_pending", exp_q.size(), 0);

      // "-." : decrement wraps.
      exp_q.push_back(8'hFF);
      begin_test("-.");
      wait_halt("dec", 100, cyc);
      chk8("dec_mem80", mem[8'h80], 8'hFF);
      chk32("dec_pending", exp_q.size(), 0);

      // "<" with DATA_BASE=0 wraps the data pointer.
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      repeat (8) step();
      chk8("left_dataptr", dataptr0, 8'hFF);
      chk8("left_instptr", instptr0, 8'h01);
      chk1("left_halted", halted0, 1'b1);
      chk1("left_error", error0, 1'b0);
      chk1("left_busy", busy0, 1'b0);
      chk1("left_memwrite", memwrite0, 1'b0);
      chk8("left_datain", datain0, 8'h00);
      chk8("left_out_data", out_data0, 8'h00);
      chk1("left_out_valid", out_valid0, 1'b0);
      chk1("left_in_ready", in_ready0, 1'b0);

      // ",." with input delayed 5 cycles.
      exp_q.push_back(8'h41);
      begin_test(",.");
      n = 0;
      while (n < 20 && !in_ready) begin
         step();
         n++;
      end
      chk1("in_ready_rise", in_ready, 1'b1);
      for (int k = 0; k < 5; k++) begin
         chk1("in_ready_held", in_ready, 1'b1);
         step();
      end
      in_data  = 8'h41;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk1("in_ready_drop", in_ready, 1'b0);
      wait_halt("in", 100, cyc);
      chk8("in_mem80", mem[8'h80], 8'h41);
      chk32("in_pending", exp_q.size(), 0);

      // "++[-]." : loop twice, backward scan.
      exp_q.push_back(8'h00);
      begin_test("++[-].");
      wait_halt("loop", 200, cyc);
      chk32("loop_cycles", cyc, 28);
      chk8("loop_mem80", mem[8'h80], 8'h00);
      chk1("loop_error", error, 1'b0);
      chk32("loop_pending", exp_q.size(), 0);

      // "[[]" : unmatched, forward scan reaches the end of memory.
      begin_test("[[]");
      wait_halt("unmatched", 1000, cyc);
      chk32("unmatched_cycles", cyc, 513);
      chk1("unmatched_error", error, 1'b1);
      chk1("unmatched_halted", halted, 1'b1);
      chk1("unmatched_busy", busy, 1'b0);
      chk8("unmatched_instptr", instptr, 8'hFF);

      // "+[>+<-]>." : move a cell.
      exp_q.push_back(8'h01);
      begin_test("+[>+<-]>.");
      wait_halt("move", 300, cyc);
      chk8("move_mem80", mem[8'h80], 8'h00);
      chk8("move_mem81", mem[8'h81], 8'h01);
      chk8("move_dataptr", dataptr, 8'h81);
      chk32("move_pending", exp_q.size(), 0);

      // Reset during an OUT stall.
      exp_q.push_back(8'h01);
      begin_test("+.");
      out_ready = 1'b0;
      wait_out_valid("stall_valid");
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk1("rstmid_out_valid", out_valid, 1'b0);
      chk1("rstmid_busy", busy, 1'b0);
      chk8("rstmid_instptr", instptr, 8'h00);
      chk1("rstmid_memwrite", memwrite, 1'b0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) step();
      chk1("rstmid_idle_busy", busy, 1'b0);
      chk1("rstmid_idle_halted", halted, 1'b0);
      chk1("rstmid_idle_valid", out_valid, 1'b0);

      // out_ready low for 10 cycles; a start pulse while busy is ignored.
      exp_q.push_back(8'h02);
      begin_test("++.");
      out_ready = 1'b0;
      wait_out_valid("hold_valid");
      for (int k = 0; k < 10; k++) begin
         if (k == 5) start = 1'b1;
         step();
      end
      chk1("hold_busy", busy, 1'b1);
      out_ready = 1'b1;
      wait_halt("hold", 100, cyc);
      repeat (10) step();
      chk8("hold_mem80", mem[8'h80], 8'h02);
      chk8("hold_instptr", instptr, 8'h03);
      chk32("hold_pending", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
